// File: rtl/program_counter_stacked.sv
// Handshake-driven program counter with jump, skip, and call/return through a
// LIFO return stack; stack overflow/underflow latch a sticky error flag.
module program_counter_stacked #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    STACK_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_prev,
    output logic                           ack_prev,
    output logic                           req_next,
    input  logic                           ack_next,
    input  logic                           write,
    input  logic                           call,
    input  logic                           ret,
    input  logic                           skip,
    input  logic [ADDR_WIDTH-1:0]          address_in,
    output logic [ADDR_WIDTH-1:0]          address_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level,
    output logic                           stack_err
);

    localparam int LW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, REQ, ACKED, WAIT_REL} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [LW-1:0]         level_q, level_d;
    logic                  err_q, err_d;
    logic                  ack_prev_q, req_next_q;
    logic                  rel_seen_q;
    logic                  push_en;
    logic                  accept;
    logic                  stack_full;
    logic [ADDR_WIDTH-1:0] pc_inc1;
    logic [IW-1:0]         push_idx, pop_idx;

    // A request is only honoured once req_prev has been observed low since reset,
    // so a handshake aborted by reset cannot be replayed by a stuck request.
    assign accept     = (state_q == IDLE) && req_prev && !ack_next && rel_seen_q;
    assign stack_full = (level_q == LW'(STACK_DEPTH));
    assign pc_inc1    = pc_q + ADDR_WIDTH'(1);
    assign push_idx   = IW'(level_q);
    assign pop_idx    = IW'(level_q - LW'(1));

    always_comb begin
        pc_d    = pc_q;
        level_d = level_q;
        err_d   = err_q;
        push_en = 1'b0;
        if (accept) begin
            if (ret) begin
                if (level_q != '0) begin
                    pc_d    = stack_q[pop_idx];
                    level_d = level_q - LW'(1);
                end else begin
                    pc_d  = pc_inc1;
                    err_d = 1'b1;
                end
            end else if (call) begin
                pc_d = address_in;
                if (stack_full) begin
                    err_d = 1'b1;
                end else begin
                    push_en = 1'b1;
                    level_d = level_q + LW'(1);
                end
            end else if (write) begin
                pc_d = address_in;
            end else if (skip) begin
                pc_d = pc_q + ADDR_WIDTH'(2);
            end else begin
                pc_d = pc_inc1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_ADDR;
            level_q    <= '0;
            err_q      <= 1'b0;
            ack_prev_q <= 1'b0;
            req_next_q <= 1'b0;
            rel_seen_q <= !req_prev;
        end else begin
            pc_q    <= pc_d;
            level_q <= level_d;
            err_q   <= err_d;
            if (!req_prev) begin
                rel_seen_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q    <= REQ;
                        req_next_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (ack_next) begin
                        state_q    <= ACKED;
                        req_next_q <= 1'b0;
                        ack_prev_q <= 1'b1;
                    end
                end
                ACKED: begin
                    if (!req_prev) begin
                        state_q    <= WAIT_REL;
                        ack_prev_q <= 1'b0;
                    end
                end
                WAIT_REL: begin
                    if (!ack_next) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stack storage holds data only; validity is tracked by level_q.
    always_ff @(posedge clk) begin
        if (push_en && !reset) begin
            stack_q[push_idx] <= pc_inc1;
        end
    end

    assign ack_prev    = ack_prev_q;
    assign req_next    = req_next_q;
    assign address_out = pc_q;
    assign stack_level = level_q;
    assign stack_err   = err_q;

endmodule

// File: tb/tb_program_counter_stacked.sv
// Self-checking bench: directed vector table, reset-abort sequence, and random
// operations checked against a queue-based reference model.
module tb_program_counter_stacked;

    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset, req_prev, ack_next;
    logic          write, call, ret, skip;
    logic [AW-1:0] address_in;
    logic          ack_prev, req_next, stack_err;
    logic [AW-1:0] address_out;
    logic [LW-1:0] stack_level;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_pc;
    int m_stk[$];
    int m_err;

    program_counter_stacked #(.ADDR_WIDTH(AW), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .req_prev(req_prev), .ack_prev(ack_prev),
        .req_next(req_next), .ack_next(ack_next), .write(write), .call(call),
        .ret(ret), .skip(skip), .address_in(address_in), .address_out(address_out),
        .stack_level(stack_level), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       w, c, r, s;
        logic [7:0] addr;
        logic [7:0] exp_addr;
        int         exp_lvl;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc  = 255;
        m_stk = {};
        m_err = 0;
    endtask

    task automatic model_op(input logic w, input logic c, input logic r,
                            input logic s, input int a);
        if (r) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_pc = (m_pc + 1) % 256; m_err = 1; end
        end else if (c) begin
            if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % 256);
            else m_err = 1;
            m_pc = a;
        end else if (w) begin
            m_pc = a;
        end else if (s) begin
            m_pc = (m_pc + 2) % 256;
        end else begin
            m_pc = (m_pc + 1) % 256;
        end
    endtask

    // One full four-phase transaction; controls are scrambled after the
    // accepting edge to show they are ignored while the fetch is pending.
    task automatic do_op(input logic w, input logic c, input logic r,
                         input logic s, input logic [7:0] a);
        @(negedge clk);
        write = w; call = c; ret = r; skip = s; address_in = a;
        req_prev = 1'b1;
        model_op(w, c, r, s, a);
        @(negedge clk);
        check("req_next_latency", req_next, 1);
        check("ack_prev_early", ack_prev, 0);
        check("addr_accept", address_out, m_pc);
        write = 1'b1; call = 1'b1; ret = 1'b1; skip = 1'b1;
        address_in = 8'($urandom);
        @(negedge clk);
        check("addr_in_req", address_out, m_pc);
        check("req_next_held", req_next, 1);
        ack_next = 1'b1;
        @(negedge clk);
        check("req_next_drop", req_next, 0);
        check("ack_prev_rise", ack_prev, 1);
        req_prev = 1'b0;
        write = 1'b0; call = 1'b0; ret = 1'b0; skip = 1'b0;
        @(negedge clk);
        check("ack_prev_fall", ack_prev, 0);
        ack_next = 1'b0;
        check("level", stack_level, m_stk.size());
        check("err", stack_err, m_err);
        check("addr_stable", address_out, m_pc);
    endtask

    task automatic add(input logic w, input logic c, input logic r, input logic s,
                       input logic [7:0] a, input logic [7:0] ea, input int el,
                       input logic ee);
        vec_t v;
        v.w = w; v.c = c; v.r = r; v.s = s; v.addr = a;
        v.exp_addr = ea; v.exp_lvl = el; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1; req_prev = 1'b0; ack_next = 1'b0;
        write = 1'b0; call = 1'b0; ret = 1'b0; skip = 1'b0; address_in = '0;

        //  w  c  r  s  addr   exp    lvl err
        add(0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(0, 0, 0, 0, 8'h00, 8'h01, 0, 0);
        add(0, 0, 0, 0, 8'h00, 8'h02, 0, 0);
        add(1, 0, 0, 0, 8'h05, 8'h05, 0, 0);
        add(0, 1, 0, 0, 8'h40, 8'h40, 1, 0);
        add(0, 0, 1, 0, 8'h00, 8'h06, 0, 0);
        add(1, 0, 0, 0, 8'hFE, 8'hFE, 0, 0);
        add(0, 0, 0, 1, 8'h00, 8'h00, 0, 0);
        add(1, 0, 0, 0, 8'hFF, 8'hFF, 0, 0);
        add(0, 0, 0, 1, 8'h00, 8'h01, 0, 0);
        add(1, 0, 0, 0, 8'hFF, 8'hFF, 0, 0);
        add(0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(1, 0, 0, 0, 8'h10, 8'h10, 0, 0);
        add(0, 1, 0, 0, 8'h20, 8'h20, 1, 0);
        add(0, 1, 0, 0, 8'h30, 8'h30, 2, 0);
        add(0, 1, 0, 0, 8'h40, 8'h40, 3, 0);
        add(0, 1, 0, 0, 8'h50, 8'h50, 4, 0);
        add(0, 1, 0, 0, 8'h60, 8'h60, 4, 1);
        add(0, 0, 1, 0, 8'h00, 8'h41, 3, 1);
        add(0, 0, 1, 0, 8'h00, 8'h31, 2, 1);
        add(0, 0, 1, 0, 8'h00, 8'h21, 1, 1);
        add(0, 0, 1, 0, 8'h00, 8'h11, 0, 1);
        add(0, 0, 1, 0, 8'h00, 8'h12, 0, 1);
        add(0, 1, 0, 0, 8'h80, 8'h80, 1, 1);
        add(1, 0, 1, 0, 8'h99, 8'h13, 0, 1);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_addr", address_out, 8'hFF);
        check("rst_level", stack_level, 0);
        check("rst_err", stack_err, 0);
        check("rst_req_next", req_next, 0);
        check("rst_ack_prev", ack_prev, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            do_op(vecs[i].w, vecs[i].c, vecs[i].r, vecs[i].s, vecs[i].addr);
            check($sformatf("vec%0d_addr", i), address_out, vecs[i].exp_addr);
            check($sformatf("vec%0d_lvl", i), stack_level, vecs[i].exp_lvl);
            check($sformatf("vec%0d_err", i), stack_err, vecs[i].exp_err);
        end

        // Reset during REQ with the request still asserted
        @(negedge clk);
        req_prev = 1'b1;
        @(negedge clk);
        check("pre_abort_req", req_next, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("abort_addr", address_out, 8'hFF);
        check("abort_req_next", req_next, 0);
        check("abort_ack_prev", ack_prev, 0);
        check("abort_level", stack_level, 0);
        check("abort_err", stack_err, 0);
        repeat (4) @(negedge clk);
        check("abort_no_accept_req", req_next, 0);
        check("abort_no_accept_addr", address_out, 8'hFF);
        req_prev = 1'b0;
        do_op(0, 0, 0, 0, 8'h00);
        check("post_abort_addr", address_out, 8'h00);

        // Stale ack_next holds IDLE
        @(negedge clk);
        ack_next = 1'b1; req_prev = 1'b1;
        repeat (2) @(negedge clk);
        check("stale_ack_req", req_next, 0);
        check("stale_ack_addr", address_out, m_pc);
        ack_next = 1'b0; req_prev = 1'b0;

        for (int n = 0; n < 300; n++) begin
            int k;
            logic w, c, r, s;
            k = $urandom_range(0, 9);
            w = (k == 0); c = (k inside {1, 2}); r = (k inside {3, 4}); s = (k == 5);
            if ($urandom_range(0, 7) == 0) begin w = 1'b1; r = 1'b1; end
            do_op(w, c, r, s, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
